// File: rtl/tpu_package.sv
// Shared TPU types and constants used by the accumulator read-address generator.
package tpu_package;

  localparam int MUL_SIZE   = 32;
  localparam int ACC_DEPTH  = 128;
  localparam int ACC_ADDR_W = $clog2(ACC_DEPTH);

  typedef logic [ACC_ADDR_W-1:0] acc_addr_t;

  typedef enum logic {
    NORMAL = 1'b0,
    DIAG   = 1'b1
  } acc_rd_mode;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } acc_gen_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/acc_addr_col.sv
// One accumulator column: combinational read enable / row address for step t.
// ACC_ADDR_WRAP_EN selects circular addressing instead of out-of-range suppression.
module acc_addr_col
  import tpu_package::*;
#(
  parameter int DEPTH  = ACC_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int TW     = $clog2(DEPTH + MUL_SIZE) + 1,
  parameter int COL    = 0
) (
  input  logic [TW-1:0]     t,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   num_rows,
  input  acc_rd_mode        mode,
  output logic              en,
  output logic [ADDR_W-1:0] addr,
  output logic              oor
);

  localparam int SW = max_int(TW, ADDR_W + 1) + 1;
  localparam logic [SW-1:0] COL_S   = SW'(COL);
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [SW-1:0] t_s;
  logic [SW-1:0] lag;
  logic [SW-1:0] off;
  logic [SW-1:0] sum;
  logic          active;
`ifdef ACC_ADDR_WRAP_EN
  logic [SW-1:0] wrapped;
`endif

  always_comb begin
    t_s = SW'(t);
    lag = t_s - COL_S;
    if (mode == DIAG) begin
      // column c sees the diagonal wavefront c steps after column 0
      active = (t_s >= COL_S) && (lag < SW'(num_rows));
      off    = lag;
    end else begin
      active = t_s < SW'(num_rows);
      off    = t_s;
    end
    sum  = SW'(base) + off;
    en   = 1'b0;
    addr = '0;
    oor  = 1'b0;
`ifdef ACC_ADDR_WRAP_EN
    wrapped = (sum >= DEPTH_S) ? (sum - DEPTH_S) : sum;
    en      = active;
    if (active) addr = ADDR_W'(wrapped);
`else
    en  = active && (sum < DEPTH_S);
    oor = active && (sum >= DEPTH_S);
    if (en) addr = ADDR_W'(sum);
`endif
  end

endmodule

// File: rtl/acc_addr_gen.sv
// Accumulator read-sweep address generator (NORMAL broadcast / DIAG skewed).
// Optional macro ACC_ADDR_WRAP_EN: circular row addressing modulo DEPTH.
module acc_addr_gen
  import tpu_package::*;
#(
  parameter int N_COLS = MUL_SIZE,
  parameter int DEPTH  = ACC_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [ADDR_W:0]          num_rows,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic [N_COLS-1:0]        rd_en,
  output logic [N_COLS*ADDR_W-1:0] rd_addr,
  output logic                     err
);

  localparam int TW = $clog2(DEPTH + N_COLS) + 1;
  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

  acc_gen_state_t      state;
  logic [TW-1:0]       t;
  logic [TW-1:0]       last;
  logic [TW-1:0]       steps;
  acc_rd_mode          mode_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     nrows_q;

  logic [N_COLS-1:0]        col_en;
  logic [N_COLS-1:0]        col_oor;
  logic [N_COLS*ADDR_W-1:0] col_addr;

  always_comb begin
    steps = mode ? (TW'(num_rows) + TW'(N_COLS - 1)) : TW'(num_rows);
  end

  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    acc_addr_col #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .TW     (TW),
      .COL    (c)
    ) u_col (
      .t        (t),
      .base     (base_q),
      .num_rows (nrows_q),
      .mode     (mode_q),
      .en       (col_en[c]),
      .addr     (col_addr[c*ADDR_W +: ADDR_W]),
      .oor      (col_oor[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      t       <= '0;
      last    <= '0;
      mode_q  <= NORMAL;
      base_q  <= '0;
      nrows_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= '0;
      rd_addr <= '0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          rd_en   <= '0;
          rd_addr <= '0;
          busy    <= 1'b0;
          if (start) begin
            mode_q  <= mode ? DIAG : NORMAL;
            base_q  <= base_addr;
            nrows_q <= num_rows;
            last    <= steps - TW'(1);
            t       <= '0;
            if ((num_rows == '0) || (num_rows > DEPTH_N)) begin
              state <= FIN;
              if (num_rows > DEPTH_N) err <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          // a stall blanks the enables but keeps the last addresses on the bus
          if (stall) begin
            rd_en <= '0;
          end else begin
            rd_en   <= col_en;
            rd_addr <= col_addr;
            if (|col_oor) err <= 1'b1;
            if (t == last) begin
              state <= FIN;
              busy  <= 1'b0;
            end else begin
              t <= t + TW'(1);
            end
          end
        end
        FIN: begin
          rd_en   <= '0;
          rd_addr <= '0;
          busy    <= 1'b0;
          done    <= 1'b1;
          t       <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_addr_gen.sv
// Scoreboard bench for acc_addr_gen with N_COLS=4, DEPTH=128.
module tb_acc_addr_gen;

  localparam int NC = 4;
  localparam int DP = 128;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          mode;
  logic          stall;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_rows;
  logic          busy;
  logic          done;
  logic          err;
  logic [NC-1:0]    rd_en;
  logic [NC*AW-1:0] rd_addr;

  always #5 clk = ~clk;

  acc_addr_gen #(
    .N_COLS (NC),
    .DEPTH  (DP),
    .ADDR_W (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .num_rows  (num_rows),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .err       (err)
  );

  typedef struct {
    logic [NC-1:0]    en;
    logic [NC*AW-1:0] addr;
    logic             done;
    logic             busy;
    logic             err;
  } item_t;

  item_t q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string cur      = "init";
  bit    exp_err  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s/%s: got %0h expected %0h", cur, tag, got, exp);
  endtask

  // Expected output stream, one item per clock edge starting at the start-sampling edge.
  task automatic build_expect(input bit m, input int base, input int n, input logic [63:0] smask);
    item_t it;
    int    T;
    int    t;
    int    k;
    int    off;
    int    s;
    int    a;
    bit    act;
    bit    e;
    logic [NC*AW-1:0] prev_addr;
    q.delete();
    prev_addr = '0;
    if (n > DP) exp_err = 1'b1;
    it.en = '0; it.addr = '0; it.done = 1'b0;
    it.busy = (n > 0) && (n <= DP);
    it.err = exp_err;
    q.push_back(it);
    if ((n > 0) && (n <= DP)) begin
      T = m ? (n + NC - 1) : n;
      t = 0;
      k = 1;
      while (t < T) begin
        it.done = 1'b0;
        if (k < 64 && smask[k]) begin
          it.en   = '0;
          it.addr = prev_addr;
          it.busy = 1'b1;
        end else begin
          for (int c = 0; c < NC; c++) begin
            off = m ? (t - c) : t;
            act = m ? ((t >= c) && (t - c < n)) : 1'b1;
            s   = base + off;
`ifdef ACC_ADDR_WRAP_EN
            e = act;
            a = act ? (s % DP) : 0;
`else
            e = act && (s < DP);
            if (act && (s >= DP)) exp_err = 1'b1;
            a = e ? s : 0;
`endif
            it.en[c] = e;
            it.addr[c*AW +: AW] = AW'(a);
          end
          t++;
          it.busy   = (t < T);
          prev_addr = it.addr;
        end
        it.err = exp_err;
        q.push_back(it);
        k++;
      end
    end
    it.en = '0; it.addr = '0; it.busy = 1'b0; it.err = exp_err;
    it.done = 1'b1;
    q.push_back(it);
    it.done = 1'b0;
    q.push_back(it);
  endtask

  task automatic run_sweep(input string name, input bit m, input int base, input int n,
                           input logic [63:0] smask, input bit hold);
    item_t it;
    int    nitems;
    cur = name;
    build_expect(m, base, n, smask);
    nitems = q.size();
    for (int i = 0; i < nitems; i++) begin
      start     = (i == 0) || (hold && (i >= 1) && (i <= nitems - 3));
      stall     = (i < 64) ? smask[i] : 1'b0;
      mode      = m;
      base_addr = AW'(base);
      num_rows  = (AW + 1)'(n);
      @(posedge clk);
      @(negedge clk);
      it = q.pop_front();
      chk($sformatf("en@%0d", i),   64'(rd_en),   64'(it.en));
      chk($sformatf("addr@%0d", i), 64'(rd_addr), 64'(it.addr));
      chk($sformatf("done@%0d", i), 64'(done),    64'(it.done));
      chk($sformatf("busy@%0d", i), 64'(busy),    64'(it.busy));
      chk($sformatf("err@%0d", i),  64'(err),     64'(it.err));
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; stall = 1'b0;
    base_addr = '0; num_rows = '0;
    repeat (3) @(negedge clk);
    cur = "reset";
    chk("en",   64'(rd_en),   64'd0);
    chk("addr", 64'(rd_addr), 64'd0);
    chk("busy", 64'(busy),    64'd0);
    chk("done", 64'(done),    64'd0);
    chk("err",  64'(err),     64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_sweep("normal_b10_n3",     1'b0, 10, 3, 64'h0, 1'b1);
    run_sweep("diag_b0_n2",        1'b1, 0,  2, 64'h0, 1'b0);
    run_sweep("diag_stall_b20_n4", 1'b1, 20, 4, 64'h19, 1'b0);
    run_sweep("normal_full_depth", 1'b0, 0,  DP, 64'h0, 1'b0);
    run_sweep("normal_rows0",      1'b0, 5,  0, 64'h0, 1'b0);
    run_sweep("diag_b124_n4",      1'b1, 124, 4, 64'h0, 1'b0);
    run_sweep("normal_b126_n4",    1'b0, 126, 4, 64'h0, 1'b0);
    run_sweep("diag_b126_n3",      1'b1, 126, 3, 64'h4, 1'b0);
    run_sweep("rows200",           1'b0, 0,  200, 64'h0, 1'b0);

    // reset in the middle of a DIAG sweep abandons it without done
    cur = "mid_reset";
    start = 1'b1; mode = 1'b1; base_addr = 7'd5; num_rows = 8'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("step0_en", 64'(rd_en), 64'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("en",   64'(rd_en),   64'd0);
    chk("addr", 64'(rd_addr), 64'd0);
    chk("busy", 64'(busy),    64'd0);
    chk("done", 64'(done),    64'd0);
    chk("err",  64'(err),     64'd0);
    rst = 1'b0;
    exp_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("quiet_done@%0d", i), 64'(done),  64'd0);
      chk($sformatf("quiet_en@%0d", i),   64'(rd_en), 64'd0);
    end

    run_sweep("after_reset_normal", 1'b0, 40, 2, 64'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/acc_addr_gen.md
ACC_ADDR_GEN -- requirements
Module: acc_addr_gen

Interface
REQ-001 SHALL have parameter N_COLS, default 32 (MUL_SIZE), meaning number of accumulator columns addressed.
REQ-002 SHALL have parameter DEPTH, default 128, meaning accumulator rows per column.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), meaning row-address width.
REQ-004 SHALL have port clk  in  1  clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  request a read sweep; sampled only in IDLE.
REQ-007 SHALL have port mode  in  1  acc_rd_mode: NORMAL or DIAG, latched at start.
REQ-008 SHALL have port base_addr  in  ADDR_W  first row, latched at start.
REQ-009 SHALL have port num_rows  in  ADDR_W+1  rows to read (0..DEPTH), latched at start.
REQ-010 SHALL have port stall  in  1  downstream not ready; freezes the sweep.
REQ-011 SHALL have port busy  out  1  high in RUN.
REQ-012 SHALL have port done  out  1  one-cycle pulse at sweep end.
REQ-013 SHALL have port rd_en  out  N_COLS  per-column read enable.
REQ-014 SHALL have port rd_addr  out  N_COLS*ADDR_W  per-column row address; column c in bits [c*ADDR_W +: ADDR_W].
REQ-015 SHALL have port err  out  1  sticky out-of-range flag.

Function
REQ-016 SHALL implement FSM IDLE, RUN, FIN: IDLE->RUN on start with 0<num_rows<=DEPTH; IDLE->FIN on start with num_rows==0 or num_rows>DEPTH; RUN->FIN after last step; FIN->IDLE unconditionally.
REQ-017 SHALL, for num_rows>DEPTH, set err and issue no reads.
REQ-018 SHALL keep step counter t, 0 at RUN entry, incrementing each non-stalled RUN cycle.
REQ-019 SHALL run T = num_rows steps in NORMAL and num_rows+N_COLS-1 steps in DIAG.
REQ-020 SHALL in NORMAL drive rd_en[c]=1 and rd_addr[c]=base+t for all c.
REQ-021 SHALL in DIAG drive rd_en[c]=(t>=c)&&(t-c<num_rows) and rd_addr[c]=base+t-c (column c lags column 0 by c cycles).
REQ-022 SHALL register rd_en/rd_addr: step t values appear the cycle after step t is evaluated; first valid output is the second cycle after start is sampled.
REQ-023 SHALL, during stall, hold t, drive rd_en all zero, and hold rd_addr.
REQ-024 SHALL pulse done the cycle the FSM is in FIN; busy low in IDLE and FIN.
REQ-025 SHALL ignore start while not in IDLE; start and stall together in IDLE still latch and start.
REQ-026 SHALL drive rd_addr all zero and rd_en zero whenever not issuing.

Reset
REQ-027 SHALL on rst force IDLE, t=0, busy=0, done=0, rd_en=0, rd_addr=0, err=0, including mid-sweep (sweep abandoned, no done).
REQ-028 SHALL clear err only by rst.

Configuration
REQ-029 SHALL honour macro ACC_ADDR_WRAP_EN: defined -> base+offset wraps modulo DEPTH (circular accumulator) and never sets err from addressing.
REQ-030 SHALL, without ACC_ADDR_WRAP_EN, suppress rd_en for any column whose base+offset >= DEPTH and set err.

Structure
REQ-031 SHALL take acc_rd_mode and MUL_SIZE from tpu_package; add there an acc_addr_t typedef and ACC_DEPTH constant (128).
REQ-032 SHALL use one sub-module, acc_addr_col, computing one column's enable/address from t, c, base, num_rows, mode; instantiated N_COLS times by generate.

Verification (N_COLS=4, DEPTH=128)
REQ-033 SHALL cover NORMAL, base=10, num_rows=3 -> rd_en=4'b1111 for 3 cycles, all addrs 10,11,12; done 1 cycle after last.
REQ-034 SHALL cover DIAG, base=0, num_rows=2 -> 5 steps; rd_en 0001,0011,0110,1100,1000; col3 addrs 0,1 on steps 3,4.
REQ-035 SHALL cover DIAG, num_rows=4, stall high 2 cycles at step 2 -> rd_en=0 for 2 cycles, sequence resumes at step 2 unchanged, done delayed 2 cycles.
REQ-036 SHALL cover base=126, num_rows=4, NORMAL -> with WRAP_EN addrs 126,127,0,1, err=0; without, steps 2-3 rd_en=0, err=1.
REQ-037 SHALL cover num_rows=0 -> done next cycle, no rd_en; num_rows=200 -> done, err=1; rst at step 1 of DIAG -> all outputs 0 next cycle, no done.
